// File: rtl/x_unloader.sv
// Captures one revolution of the x ring, restores solution order, drains it over valid/ready.
// Optional build macro X_UNLOAD_ROUND_EN: round-half-up fixed-point to integer on the output.
module x_unloader #(
    parameter int N          = 16,
    parameter int ROT_OFFSET = 0,
    parameter int FRAC       = 16,
    localparam int AW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   data_i,
    input  logic          start_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [31:0]   out_data_o,
    output logic [AW-1:0] out_idx_o,
    output logic          out_last_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    localparam logic [AW-1:0] ROT  = AW'(ROT_OFFSET);
    localparam logic [AW-1:0] LAST = AW'(N - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [31:0]   r_buf [N];
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_widx;
    logic          w_wr;
    logic          w_hs;
    logic [AW-1:0] w_rd_next;
    logic          w_valid_next;
    logic          w_last_next;
    logic          w_done_next;
    logic [31:0]   w_word_next;

    function automatic logic [31:0] fmt(input logic [31:0] x);
`ifdef X_UNLOAD_ROUND_EN
        logic [32:0] s;
        logic [32:0] r;
        s = {x[31], x} + (33'd1 << (FRAC - 1));
        if (!x[31] && s[31])
            return 32'h7FFF_FFFF >> FRAC;
        r = $signed(s) >>> FRAC;
        return r[31:0];
`else
        return x;
`endif
    endfunction

    // r_cnt idles at 0 and wraps back to 0 after the last capture, so it doubles as word index k.
    assign w_widx = r_cnt + ROT;
    assign w_wr   = (r_state == S_IDLE && start_i) || (r_state == S_CAPTURE);
    assign w_hs   = out_valid_o && out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (start_i) w_next_state = S_CAPTURE;
            S_CAPTURE: if (r_cnt == LAST) w_next_state = S_DRAIN;
            S_DRAIN:   if (w_hs && out_idx_o == LAST) w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_next    = '0;
        w_valid_next = 1'b0;
        w_done_next  = 1'b0;
        w_word_next  = '0;
        case (r_state)
            S_CAPTURE: begin
                if (r_cnt == LAST) begin
                    w_valid_next = 1'b1;
                    // Final capture word may land in slot 0 on this very edge.
                    w_word_next  = (w_widx == '0) ? data_i : r_buf[0];
                end
            end
            S_DRAIN: begin
                if (w_hs && out_idx_o == LAST) begin
                    w_done_next = 1'b1;
                end else begin
                    w_valid_next = 1'b1;
                    w_rd_next    = w_hs ? out_idx_o + 1'b1 : out_idx_o;
                    w_word_next  = r_buf[w_rd_next];
                end
            end
            default: ;
        endcase
        w_last_next = w_valid_next && (w_rd_next == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_idx_o   <= '0;
            out_last_o  <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            out_valid_o <= w_valid_next;
            out_data_o  <= fmt(w_word_next);
            out_idx_o   <= w_rd_next;
            out_last_o  <= w_last_next;
            busy_o      <= (w_next_state != S_IDLE);
            done_o      <= w_done_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            for (int unsigned i = 0; i < N; i++)
                r_buf[i] <= '0;
        end else if (w_wr) begin
            r_cnt         <= r_cnt + 1'b1;
            r_buf[w_widx] <= data_i;
        end
    end

endmodule

// File: tb/tb_x_unloader.sv
// Scoreboard bench: two instances (rotation 0 and 3) share stimulus; a negedge monitor pops expectations.
module tb_x_unloader;

    localparam int N    = 16;
    localparam int ROTB = 3;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  idx;
        logic        last;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_i;
    logic        start_i;
    logic        out_ready_i;

    logic        mv [2];
    logic [31:0] md [2];
    logic [3:0]  mi [2];
    logic        ml [2];
    logic        mb [2];
    logic        mdn [2];

    item_t       qa[$];
    item_t       qb[$];
    logic [31:0] w [N];
    logic [31:0] e [N];

    int vectors = 0;
    int errors  = 0;
    int acc  [2] = '{0, 0};
    int dcnt [2] = '{0, 0};

    always #5 clk = ~clk;

    x_unloader #(.N(N), .ROT_OFFSET(0), .FRAC(16)) u_a (
        .clk(clk), .rst(rst), .data_i(data_i), .start_i(start_i),
        .out_valid_o(mv[0]), .out_ready_i(out_ready_i), .out_data_o(md[0]),
        .out_idx_o(mi[0]), .out_last_o(ml[0]), .busy_o(mb[0]), .done_o(mdn[0])
    );

    x_unloader #(.N(N), .ROT_OFFSET(ROTB), .FRAC(16)) u_b (
        .clk(clk), .rst(rst), .data_i(data_i), .start_i(start_i),
        .out_valid_o(mv[1]), .out_ready_i(out_ready_i), .out_data_o(md[1]),
        .out_idx_o(mi[1]), .out_last_o(ml[1]), .busy_o(mb[1]), .done_o(mdn[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] x);
`ifdef X_UNLOAD_ROUND_EN
        longint v;
        v = longint'($signed(x)) + 64'sd32768;
        if (v > 64'sd2147483647) return 32'h0000_7FFF;
        v = v >>> 16;
        return v[31:0];
`else
        return x;
`endif
    endfunction

    // Monitor: pops on every handshake, and checks hold stability under backpressure.
    logic        hold [2] = '{1'b0, 1'b0};
    logic [31:0] hd   [2];
    logic [3:0]  hi   [2];
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                hold[i] = 1'b0;
            end else begin
                if (hold[i]) begin
                    check($sformatf("dut%0d hold_data", i), md[i], hd[i]);
                    check($sformatf("dut%0d hold_valid_idx", i), {27'd0, mv[i], mi[i]}, {27'd0, 1'b1, hi[i]});
                end
                if (mv[i] && out_ready_i) begin
                    item_t ex;
                    int    sz;
                    sz = (i == 0) ? qa.size() : qb.size();
                    if (sz == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL dut%0d extra_word: got idx %0d data %h expected none", i, mi[i], md[i]);
                    end else begin
                        ex = (i == 0) ? qa.pop_front() : qb.pop_front();
                        check($sformatf("dut%0d data idx%0d", i, ex.idx), md[i], ex.d);
                        check($sformatf("dut%0d idx", i), 32'(mi[i]), 32'(ex.idx));
                        check($sformatf("dut%0d last idx%0d", i, ex.idx), 32'(ml[i]), 32'(ex.last));
                    end
                    acc[i]++;
                end
                if (mdn[i]) dcnt[i]++;
                hold[i] = mv[i] && !out_ready_i;
                hd[i]   = md[i];
                hi[i]   = mi[i];
            end
        end
    end

    task automatic push_expect();
        for (int j = 0; j < N; j++) begin
            qa.push_back('{e[j], 4'(j), j == N - 1});
            qb.push_back('{e[(j - ROTB + N) % N], 4'(j), j == N - 1});
        end
    endtask

    task automatic capture(input bit extra_start, output bit busy_ok);
        busy_ok = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b1;
        data_i  = w[0];
        for (int k = 1; k < N; k++) begin
            @(posedge clk); #1;
            busy_ok = busy_ok && mb[0] && mb[1];
            start_i = extra_start && (k == 5);
            data_i  = w[k];
        end
        check("valid_low_in_capture", {30'd0, mv[0], mv[1]}, 32'd0);
        @(posedge clk); #1;
        start_i = 1'b0;
        data_i  = 'x;
        check("first_valid_cycle_N", {30'd0, mv[0], mv[1]}, 32'd3);
    endtask

    // mode 0: ready always 1; mode 1: ready 1,0,0 repeating; mode 2: random ready.
    task automatic run(input int mode, input bit extra_start, input bit check_lat);
        int cyc;
        int done_at;
        int d0;
        bit busy_ok;
        d0 = dcnt[0];
        push_expect();
        capture(extra_start, busy_ok);
        cyc     = N;
        done_at = -1;
        while (cyc < 8 * N + 40) begin
            if (mdn[0]) begin
                done_at = cyc;
                break;
            end
            busy_ok     = busy_ok && mb[0] && mb[1];
            out_ready_i = (mode == 0) ? 1'b1 :
                          (mode == 1) ? (((cyc - N) % 3) == 0) : 1'($urandom_range(0, 1));
            start_i     = extra_start && (cyc == N + 3);
            @(posedge clk); #1;
            cyc++;
        end
        if (done_at < 0) begin
            vectors++;
            errors++;
            $display("FAIL done_timeout: got no done_o expected a pulse within %0d cycles", 8 * N + 40);
        end
        if (check_lat) check("done_cycle", 32'(done_at), 32'(2 * N));
        check("done_both", {31'd0, mdn[1]}, 32'd1);
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        check("done_one_cycle_idle", {26'd0, mdn[0], mdn[1], mv[0], mv[1], mb[0], mb[1]}, 32'd0);
        check("done_count", 32'(dcnt[0] - d0), 32'd1);
        check("scoreboard_empty", 32'(qa.size() + qb.size()), 32'd0);
        if (extra_start) check("busy_held", {31'd0, busy_ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of run");
        $fatal(1);
    end

    initial begin
        bit unused;
        int a0;
        rst         = 1'b1;
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        data_i      = '0;
        #2;
        check("reset_state_a", {md[0] | {27'd0, mv[0], ml[0], mb[0], mdn[0], 1'b0}}, 32'd0);
        check("reset_idx", {24'd0, mi[0], mi[1]}, 32'd0);
        check("reset_state_b", {md[1] | {27'd0, mv[1], ml[1], mb[1], mdn[1], 1'b0}}, 32'd0);
        @(posedge clk); #3;
        rst = 1'b0;

        // Basic ordering plus latency
        for (int k = 0; k < N; k++) begin w[k] = 32'(k) << 16; e[k] = model(w[k]); end
        run(0, 1'b0, 1'b1);
        // Rotation-visible data
        for (int k = 0; k < N; k++) begin w[k] = 32'(100 + k); e[k] = model(w[k]); end
        run(0, 1'b0, 1'b0);
        // Backpressure 1,0,0 pattern
        for (int k = 0; k < N; k++) begin w[k] = 32'(k + 1) * 32'h0101_0101; e[k] = model(w[k]); end
        run(1, 1'b0, 1'b0);
        // Random backpressure
        for (int k = 0; k < N; k++) begin w[k] = $urandom; e[k] = model(w[k]); end
        run(2, 1'b0, 1'b0);
        // Ignored starts during capture and drain
        for (int k = 0; k < N; k++) begin w[k] = 32'(k) << 16; e[k] = model(w[k]); end
        run(0, 1'b1, 1'b1);

        // Async reset after 7 accepts in DRAIN
        for (int k = 0; k < N; k++) begin w[k] = 32'h5000 + 32'(k); e[k] = model(w[k]); end
        a0 = acc[0];
        push_expect();
        capture(1'b0, unused);
        for (int k = 0; k < 7; k++) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {26'd0, mv[0], mv[1], mb[0], mb[1], mdn[0], mdn[1]}, 32'd0);
        check("accepts_before_reset", 32'(acc[0] - a0), 32'd7);
        qa.delete();
        qb.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        for (int k = 0; k < N; k++) begin w[k] = 32'hA000_0000 + 32'(k); e[k] = model(w[k]); end
        run(0, 1'b0, 1'b1);

        // Rounding corner values (raw pass-through without the macro)
        for (int k = 0; k < N; k++) begin w[k] = '0; e[k] = '0; end
        w[0] = 32'h0001_8000;
        w[1] = 32'hFFFE_8000;
        w[2] = 32'h7FFF_FFFF;
`ifdef X_UNLOAD_ROUND_EN
        e[0] = 32'h0000_0002;
        e[1] = 32'hFFFF_FFFF;
        e[2] = 32'h0000_7FFF;
`else
        e[0] = 32'h0001_8000;
        e[1] = 32'hFFFE_8000;
        e[2] = 32'h7FFF_FFFF;
`endif
        run(0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
